// File: rtl/fade_sequencer.sv
// Timed duty-table player that ramps pwm_value toward each step's target.
// Define SEQ_RAMP_EN for rate-limited ramps; otherwise steps are applied hard.
module fade_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int NUM_STEPS    = 8,
  parameter int STEP_CYCLES  = 1200000,
  parameter int RAMP_CYCLES  = 1200,
  parameter int RAMP_DELTA   = 4,
  localparam int VW = $clog2(PWM_INTERVAL),
  localparam int AW = $clog2(NUM_STEPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [VW-1:0] wr_data,
  output logic [VW-1:0] pwm_value,
  output logic [AW-1:0] step_idx,
  output logic          step_strobe,
  output logic          busy
);

  localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [VW-1:0] MAXV = VW'(PWM_INTERVAL - 1);

  if (NUM_STEPS < 2 || (NUM_STEPS & (NUM_STEPS - 1)) != 0 ||
      RAMP_CYCLES < 1 || RAMP_DELTA < 1 || STEP_CYCLES < 1)
  begin : g_bad_cfg
    $error("fade_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    FADE
  } state_t;

  state_t state, state_nx;

  logic [VW-1:0]  tbl [NUM_STEPS];
  logic [VW-1:0]  wr_clip;
  logic [VW-1:0]  target;
  logic [VW-1:0]  upd;
  logic [VW-1:0]  pwm_nx;
  logic [AW-1:0]  idx_nx;
  logic [SCW-1:0] scnt, scnt_nx;
  logic           step_wrap;
  logic           strobe_nx;

  assign wr_clip   = (wr_data > MAXV) ? MAXV : wr_data;
  assign target    = (state == FADE) ? '0 : tbl[step_idx];
  assign step_wrap = (scnt == SCW'(STEP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_clip;
    end
  end

`ifdef SEQ_RAMP_EN
  localparam int RCW  = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int DLIM = (RAMP_DELTA < PWM_INTERVAL) ? RAMP_DELTA
                                                    : PWM_INTERVAL;
  localparam logic [VW:0] DELTA = (VW+1)'(DLIM);

  logic [RCW-1:0] rcnt, rcnt_nx;
  logic           ramp_tick;
  logic [VW:0]    cur, tgt, diff, ramped;

  assign ramp_tick = (rcnt == RCW'(RAMP_CYCLES - 1));
  assign cur       = {1'b0, pwm_value};
  assign tgt       = {1'b0, target};

  // Step by at most DELTA, landing exactly on the target when close.
  always_comb begin
    diff   = '0;
    ramped = cur;
    if (tgt > cur) begin
      diff   = tgt - cur;
      ramped = (diff > DELTA) ? cur + DELTA : tgt;
    end else if (tgt < cur) begin
      diff   = cur - tgt;
      ramped = (diff > DELTA) ? cur - DELTA : tgt;
    end
  end

  assign upd = ramp_tick ? ramped[VW-1:0] : pwm_value;

  always_ff @(posedge clk) begin
    if (reset) rcnt <= '0;
    else       rcnt <= rcnt_nx;
  end
`else
  assign upd = target;
`endif

  always_comb begin
    state_nx  = state;
    pwm_nx    = pwm_value;
    idx_nx    = step_idx;
    scnt_nx   = scnt;
    strobe_nx = 1'b0;
`ifdef SEQ_RAMP_EN
    rcnt_nx   = rcnt;
`endif
    unique case (state)
      IDLE: begin
        pwm_nx = '0;
        if (run) begin
          state_nx = PLAY;
          idx_nx   = '0;
          scnt_nx  = '0;
`ifdef SEQ_RAMP_EN
          rcnt_nx  = '0;
`endif
        end
      end
      PLAY: begin
        pwm_nx = upd;
`ifdef SEQ_RAMP_EN
        rcnt_nx = ramp_tick ? '0 : rcnt + RCW'(1);
`endif
        if (!run) begin
          state_nx = FADE;
        end else if (step_wrap) begin
          scnt_nx   = '0;
          idx_nx    = step_idx + AW'(1);
          strobe_nx = 1'b1;
        end else begin
          scnt_nx = scnt + SCW'(1);
        end
      end
      FADE: begin
`ifdef SEQ_RAMP_EN
        pwm_nx  = upd;
        rcnt_nx = ramp_tick ? '0 : rcnt + RCW'(1);
        if (run) begin
          // Resume from the current level; no jump back to the table.
          state_nx = PLAY;
          pwm_nx   = pwm_value;
          idx_nx   = '0;
          scnt_nx  = '0;
          rcnt_nx  = '0;
        end else if (pwm_value == '0) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end
`else
        pwm_nx   = '0;
        state_nx = IDLE;
        idx_nx   = '0;
`endif
      end
      default: begin
        state_nx = IDLE;
        pwm_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pwm_value   <= '0;
      step_idx    <= '0;
      scnt        <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      pwm_value   <= pwm_nx;
      step_idx    <= idx_nx;
      scnt        <= scnt_nx;
      step_strobe <= strobe_nx;
      busy        <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_fade_sequencer.sv
// Directed bench for fade_sequencer; expectations follow SEQ_RAMP_EN.
// Table vectors cover reset/writes, checkpoints cover the play/fade runs.
module tb_fade_sequencer;

  localparam int VW = 11;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [VW-1:0] wr_data;
  logic [VW-1:0] pwm_value;
  logic [AW-1:0] step_idx;
  logic          step_strobe;
  logic          busy;

  int errs   = 0;
  int checks = 0;

  fade_sequencer #(
    .PWM_INTERVAL(1200),
    .NUM_STEPS   (4),
    .STEP_CYCLES (20),
    .RAMP_CYCLES (2),
    .RAMP_DELTA  (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_value  (pwm_value),
    .step_idx   (step_idx),
    .step_strobe(step_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          r;
    logic          we;
    logic [AW-1:0] a;
    logic [VW-1:0] d;
    int            p;
    int            i;
    int            s;
    int            b;
  } vec_t;

  typedef struct {
    int e;
    int p;
    int i;
    int s;
  } cp_t;

  vec_t vt[6];
  cp_t  cp[15];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic all4(input string nm, input int p, input int i,
                      input int s, input int b);
    chk({nm, "_pwm"}, 32'(pwm_value), p);
    chk({nm, "_idx"}, 32'(step_idx), i);
    chk({nm, "_strobe"}, 32'(step_strobe), s);
    chk({nm, "_busy"}, 32'(busy), b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int k;
  int nstr;
  int ep [15];
  int pv [15];
  int iv [15];
  int sv [15];

  initial begin
    // reset with run/wr_en asserted must not start or write
    vt[0] = '{1'b1, 1'b1, 1'b1, 2'd2, 11'd77,   0, 0, 0, 0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 2'd2, 11'd77,   0, 0, 0, 0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 2'd0, 11'd550,  0, 0, 0, 0};
    vt[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 11'd1000, 0, 0, 0, 0};
    vt[4] = '{1'b0, 1'b0, 1'b1, 2'd3, 11'd2047, 0, 0, 0, 0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 11'd0,    0, 0, 0, 0};

    ep = '{0, 1, 2, 10, 12, 19, 20, 21, 22, 30, 41, 60, 61, 80, 81};
    iv = '{0, 0, 0, 0,  0,  0,  1,  1,  1,  1,  2,  3,  3,  0,  0};
    sv = '{0, 0, 0, 0,  0,  0,  1,  0,  0,  0,  0,  1,  0,  1,  0};
`ifdef SEQ_RAMP_EN
    pv = '{0, 0, 100, 500, 550, 550, 550, 550, 650, 1000,
           1000, 0, 0, 1000, 1000};
`else
    pv = '{0, 550, 550, 550, 550, 550, 550, 1000, 1000, 1000,
           0, 0, 1199, 1199, 550};
`endif
    for (int j = 0; j < 15; j++) cp[j] = '{ep[j], pv[j], iv[j], sv[j]};

    for (int j = 0; j < 6; j++) begin
      reset   = vt[j].rst;
      run     = vt[j].r;
      wr_en   = vt[j].we;
      wr_addr = vt[j].a;
      wr_data = vt[j].d;
      tick(1);
      all4($sformatf("vec%0d", j), vt[j].p, vt[j].i, vt[j].s, vt[j].b);
    end

    run  = 1'b1;
    k    = 0;
    nstr = 0;
    for (int e = 0; e <= 81; e++) begin
      tick(1);
      if (step_strobe === 1'b1) nstr++;
      if (k < 15 && cp[k].e == e) begin
        all4($sformatf("play_e%0d", e), cp[k].p, cp[k].i, cp[k].s, 1);
        k++;
      end
    end
    chk("strobe_count", nstr, 4);

`ifdef SEQ_RAMP_EN
    tick(5);
    all4("ramp_e86", 700, 0, 0, 1);
    run = 1'b0;
    tick(1);
    all4("fade_e87", 700, 0, 0, 1);
    tick(1);
    all4("fade_e88", 600, 0, 0, 1);
    tick(6);
    all4("fade_e94", 300, 0, 0, 1);
    run = 1'b1;
    tick(1);
    all4("resume_e95", 300, 0, 0, 1);
    tick(2);
    all4("resume_e97", 400, 0, 0, 1);
    tick(4);
    all4("resume_e101", 550, 0, 0, 1);
    tick(14);
    all4("resume_e115", 550, 1, 1, 1);
    run = 1'b0;
    tick(1);
    all4("fade2_e116", 550, 1, 0, 1);
    tick(11);
    all4("fade2_e127", 0, 1, 0, 1);
    tick(1);
    all4("idle_e128", 0, 0, 0, 0);
`else
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = 11'd600;
    tick(1);
    wr_en = 1'b0;
    all4("wr_e82", 550, 0, 0, 1);
    tick(1);
    all4("wr_e83", 600, 0, 0, 1);
    tick(17);
    all4("hard_e100", 600, 1, 1, 1);
    run = 1'b0;
    tick(1);
    all4("fade_e101", 1000, 1, 0, 1);
    tick(1);
    all4("idle_e102", 0, 0, 0, 0);
    tick(1);
    all4("idle_e103", 0, 0, 0, 0);
`endif

    run = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(1);
    all4("rst_mid", 0, 0, 0, 0);
    reset = 1'b0;
    tick(1);
    all4("rst_run0", 0, 0, 0, 1);
    tick(3);
    all4("rst_tblclr", 0, 0, 0, 1);
    run = 1'b0;
    tick(3);
    all4("rst_stop", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
